core_rrv_rf_sb: RTL and testbench
=================================

CORE_RRV_RF_SB -- requirements
Module: core_rrv_rf_sb

Interface
REQ-001 SHALL have parameter RF_NUM_MSB, default 31, highest implemented register index (15 = RV32E).
REQ-002 SHALL have parameter NUM_RD, default 2, number of read ports (1..4).
REQ-003 SHALL have parameter NUM_WR, default 1, number of write ports (1..2); higher index = younger.
REQ-004 SHALL have parameter DATA_W, default 32, register width.
REQ-005 SHALL use one clock and a synchronous, active-high reset.
REQ-006 Clock  in  1  core clock; all state updates on its rising edge.
REQ-007 Rst  in  1  reset.
REQ-008 RegSrcQ101H  in  NUM_RD x 5  read source indices.
REQ-009 IssueValidQ101H  in  1  instruction in Q101H issues this cycle (ReadyQ102H high, no hazard).
REQ-010 IssueDstQ101H  in  5  destination of issuing instruction; IssueRegWrQ101H  in  1  it writes a register.
REQ-011 RegWrEnQ105H  in  NUM_WR  write enables; RegDstQ105H  in  NUM_WR x 5; RegWrDataQ105H  in  NUM_WR x DATA_W.
REQ-012 FlushQ101H  in  1  pipeline flush; clears scoreboard.
REQ-013 ReadyQ102H  in  1  Q102H capture enable; PcQ101H, ImmediateQ101H  in  32 each.
REQ-014 PcQ102H, ImmediateQ102H  out  32 each; RegRdDataQ102H  out  NUM_RD x DATA_W.
REQ-015 HazardQ101H  out  1  some source is pending; BusyVecQ101H  out  RF_NUM_MSB+1  scoreboard view.

Function
REQ-016 Register storage SHALL hold indices 1..RF_NUM_MSB; index 0 and indices >RF_NUM_MSB SHALL read 0 and ignore writes.
REQ-017 Write on port w SHALL update storage at the next edge when RegWrEnQ105H[w] set and dst legal and nonzero.
REQ-018 Two ports writing same dst in one cycle: port NUM_WR-1 data SHALL be stored.
REQ-019 Read in Q101H SHALL forward same-cycle RegWrDataQ105H on dst match with enable (youngest matching port wins), else storage.
REQ-020 Read data, Pc, Immediate SHALL be captured into Q102H outputs only when ReadyQ102H high; held otherwise (latency 1 cycle).
REQ-021 Scoreboard busy bit r SHALL set at edge when IssueValidQ101H && IssueRegWrQ101H && IssueDstQ101H==r, r legal nonzero.
REQ-022 Busy bit r SHALL clear at edge when any enabled write port targets r, unless set in same cycle (set wins).
REQ-023 FlushQ101H SHALL clear all busy bits at next edge, overriding same-cycle set.
REQ-024 HazardQ101H SHALL be combinational: any RegSrcQ101H[i] busy and not forwarded from a same-cycle Q105H write.
REQ-025 Busy bit 0 and bits for illegal indices SHALL read constant 0.
REQ-026 BusyVecQ101H SHALL reflect registered scoreboard state, no same-cycle bypass.

Reset
REQ-027 Rst SHALL zero all registers, all busy bits, PcQ102H, ImmediateQ102H and all RegRdDataQ102H at next edge.
REQ-028 Rst SHALL dominate ReadyQ102H, writes, issue and flush; write arriving with Rst SHALL be lost.
REQ-029 HazardQ101H SHALL be 0 in the first cycle after reset given no issue.

Structure
REQ-030 t_rf_sb_ctrl struct (RegSrc, Dst, WrEn, IssueValid) and RF index width constant SHALL live in core_rrv_pkg.
REQ-031 Scoreboard SHALL be sub-module core_rrv_rf_scoreboard (set/clear/flush, hazard compare).
REQ-032 All flops SHALL use the codebase DFF macros with enable/reset variants.

Verification
REQ-033 Write x5=0xDEADBEEF via port0, read x5 next cycle, ReadyQ102H=1 -> RegRdDataQ102H[0]=0xDEADBEEF one cycle later.
REQ-034 Same-cycle write x7=0x11 and read x7 -> forwarded 0x11; write x0=0x55 -> x0 reads 0.
REQ-035 NUM_WR=2, both ports write x3 (0xA, 0xB) -> x3 reads 0xB; RF_NUM_MSB=15, write x20 -> ignored, reads 0.
REQ-036 Issue dst x9; next cycle read x9 -> HazardQ101H=1; Q105H writes x9 -> hazard 0 that cycle, bit cleared after.
REQ-037 Issue x4 with concurrent x4 writeback -> bit stays set; FlushQ101H -> BusyVecQ101H=0 next cycle.
REQ-038 ReadyQ102H=0 for 3 cycles with changing inputs -> Q102H outputs hold; Rst mid-run -> all outputs 0.

Source files
------------

// File: rtl/core_rrv_pkg.sv
// Shared types, constants and flop macros for the rrv core register file and scoreboard.
`ifndef CORE_RRV_DFF_MACROS
`define CORE_RRV_DFF_MACROS
`define RRV_DFF_RST(q, d, clk, rst, rv) always_ff @(posedge clk) begin if (rst) q <= rv; else q <= d; end
`define RRV_DFF_EN_RST(q, en, d, clk, rst, rv) always_ff @(posedge clk) begin if (rst) q <= rv; else if (en) q <= d; end
`endif

package core_rrv_pkg;

    localparam int RF_IDX_W  = 5;
    localparam int RF_MAX_RD = 4;

    typedef struct packed {
        logic [RF_MAX_RD-1:0][RF_IDX_W-1:0] RegSrc;
        logic [RF_IDX_W-1:0]                Dst;
        logic                               WrEn;
        logic                               IssueValid;
    } t_rf_sb_ctrl;

    // Index 0 and anything above the implemented range never hold state.
    function automatic logic f_rf_legal(input logic [RF_IDX_W-1:0] idx, input int msb);
        return (idx != 5'd0) && (int'(idx) <= msb);
    endfunction

endpackage

// File: rtl/core_rrv_rf_scoreboard.sv
// Register busy scoreboard: set on issue, clear on writeback, flush clears all; source hazard compare.
module core_rrv_rf_scoreboard
    import core_rrv_pkg::*;
#(
    parameter int RF_NUM_MSB = 31,
    parameter int NUM_WR     = 1
) (
    input  logic                         Clock,
    input  logic                         Rst,
    input  t_rf_sb_ctrl                  i_ctrl,
    input  logic                         i_flush,
    input  logic [NUM_WR-1:0]            i_wb_en,
    input  logic [NUM_WR*RF_IDX_W-1:0]   i_wb_dst,
    output logic                         o_hazard,
    output logic [RF_NUM_MSB:0]          o_busy_vec
);

    logic [RF_NUM_MSB:1] r_busy;
    logic [RF_NUM_MSB:1] w_busy_nxt;
    logic [31:0]         w_busy_all;
    logic [31:0]         w_wb_hit;
    logic                w_hazard;

    always_comb begin
        w_wb_hit = 32'd0;
        for (int w = 0; w < NUM_WR; w++) begin
            w_wb_hit[i_wb_dst[w*RF_IDX_W +: RF_IDX_W]] =
                w_wb_hit[i_wb_dst[w*RF_IDX_W +: RF_IDX_W]] | i_wb_en[w];
        end
    end

    // Priority per bit: flush, then issue set, then writeback clear.
    always_comb begin
        w_busy_nxt = r_busy;
        for (int r = 1; r <= RF_NUM_MSB; r++) begin
            w_busy_nxt[r] = i_flush ? 1'b0 :
                            (i_ctrl.IssueValid && i_ctrl.WrEn && (i_ctrl.Dst == 5'(r))) ? 1'b1 :
                            w_wb_hit[r] ? 1'b0 : r_busy[r];
        end
    end

    `RRV_DFF_RST(r_busy, w_busy_nxt, Clock, Rst, {RF_NUM_MSB{1'b0}})

    always_comb begin
        w_busy_all = 32'd0;
        w_busy_all[RF_NUM_MSB:1] = r_busy;
    end

    // A pending source is not a hazard when its value is being written back this cycle.
    always_comb begin
        w_hazard = 1'b0;
        for (int i = 0; i < RF_MAX_RD; i++) begin
            w_hazard = w_hazard | (w_busy_all[i_ctrl.RegSrc[i]] & ~w_wb_hit[i_ctrl.RegSrc[i]]);
        end
    end

    assign o_hazard   = w_hazard;
    assign o_busy_vec = w_busy_all[RF_NUM_MSB:0];

endmodule

// File: rtl/core_rrv_rf_sb.sv
// Register file with Q105H write forwarding into Q101H reads, Q102H capture stage and busy scoreboard.
module core_rrv_rf_sb
    import core_rrv_pkg::*;
#(
    parameter int RF_NUM_MSB = 31,
    parameter int NUM_RD     = 2,
    parameter int NUM_WR     = 1,
    parameter int DATA_W     = 32
) (
    input  logic                        Clock,
    input  logic                        Rst,
    input  logic [NUM_RD*RF_IDX_W-1:0]  RegSrcQ101H,
    input  logic                        IssueValidQ101H,
    input  logic [RF_IDX_W-1:0]         IssueDstQ101H,
    input  logic                        IssueRegWrQ101H,
    input  logic [NUM_WR-1:0]           RegWrEnQ105H,
    input  logic [NUM_WR*RF_IDX_W-1:0]  RegDstQ105H,
    input  logic [NUM_WR*DATA_W-1:0]    RegWrDataQ105H,
    input  logic                        FlushQ101H,
    input  logic                        ReadyQ102H,
    input  logic [31:0]                 PcQ101H,
    input  logic [31:0]                 ImmediateQ101H,
    output logic [31:0]                 PcQ102H,
    output logic [31:0]                 ImmediateQ102H,
    output logic [NUM_RD*DATA_W-1:0]    RegRdDataQ102H,
    output logic                        HazardQ101H,
    output logic [RF_NUM_MSB:0]         BusyVecQ101H
);

    logic [DATA_W-1:0]        w_rf_all [0:31];
    logic [NUM_RD*DATA_W-1:0] w_rd_data;
    logic [NUM_RD*DATA_W-1:0] r_rd_q102h;
    logic [31:0]              r_pc_q102h;
    logic [31:0]              r_imm_q102h;
    t_rf_sb_ctrl              w_sb_ctrl;

    assign w_rf_all[0] = {DATA_W{1'b0}};

    for (genvar g = 1; g <= RF_NUM_MSB; g++) begin : g_reg
        logic [DATA_W-1:0] r_q;
        logic [DATA_W-1:0] w_wd;
        logic              w_we;

        // Scanning ports upward lets the youngest port win a same-destination collision.
        always_comb begin
            w_we = 1'b0;
            w_wd = r_q;
            for (int w = 0; w < NUM_WR; w++) begin
                w_we = (RegWrEnQ105H[w] && (RegDstQ105H[w*RF_IDX_W +: RF_IDX_W] == 5'(g))) ? 1'b1 : w_we;
                w_wd = (RegWrEnQ105H[w] && (RegDstQ105H[w*RF_IDX_W +: RF_IDX_W] == 5'(g))) ?
                       RegWrDataQ105H[w*DATA_W +: DATA_W] : w_wd;
            end
        end

        `RRV_DFF_EN_RST(r_q, w_we, w_wd, Clock, Rst, {DATA_W{1'b0}})

        assign w_rf_all[g] = r_q;
    end

    for (genvar g = RF_NUM_MSB + 1; g < 32; g++) begin : g_unimpl
        assign w_rf_all[g] = {DATA_W{1'b0}};
    end

    always_comb begin
        w_rd_data = {(NUM_RD*DATA_W){1'b0}};
        for (int i = 0; i < NUM_RD; i++) begin
            w_rd_data[i*DATA_W +: DATA_W] = w_rf_all[RegSrcQ101H[i*RF_IDX_W +: RF_IDX_W]];
            for (int w = 0; w < NUM_WR; w++) begin
                w_rd_data[i*DATA_W +: DATA_W] =
                    (RegWrEnQ105H[w] &&
                     (RegDstQ105H[w*RF_IDX_W +: RF_IDX_W] == RegSrcQ101H[i*RF_IDX_W +: RF_IDX_W]) &&
                     f_rf_legal(RegSrcQ101H[i*RF_IDX_W +: RF_IDX_W], RF_NUM_MSB)) ?
                    RegWrDataQ105H[w*DATA_W +: DATA_W] : w_rd_data[i*DATA_W +: DATA_W];
            end
        end
    end

    `RRV_DFF_EN_RST(r_rd_q102h, ReadyQ102H, w_rd_data, Clock, Rst, {(NUM_RD*DATA_W){1'b0}})
    `RRV_DFF_EN_RST(r_pc_q102h, ReadyQ102H, PcQ101H, Clock, Rst, 32'd0)
    `RRV_DFF_EN_RST(r_imm_q102h, ReadyQ102H, ImmediateQ101H, Clock, Rst, 32'd0)

    assign PcQ102H        = r_pc_q102h;
    assign ImmediateQ102H = r_imm_q102h;
    assign RegRdDataQ102H = r_rd_q102h;

    always_comb begin
        w_sb_ctrl.RegSrc = {(RF_MAX_RD*RF_IDX_W){1'b0}};
        for (int i = 0; i < NUM_RD; i++) begin
            w_sb_ctrl.RegSrc[i] = RegSrcQ101H[i*RF_IDX_W +: RF_IDX_W];
        end
        w_sb_ctrl.Dst        = IssueDstQ101H;
        w_sb_ctrl.WrEn       = IssueRegWrQ101H;
        w_sb_ctrl.IssueValid = IssueValidQ101H;
    end

    core_rrv_rf_scoreboard #(
        .RF_NUM_MSB (RF_NUM_MSB),
        .NUM_WR     (NUM_WR)
    ) u_scoreboard (
        .Clock      (Clock),
        .Rst        (Rst),
        .i_ctrl     (w_sb_ctrl),
        .i_flush    (FlushQ101H),
        .i_wb_en    (RegWrEnQ105H),
        .i_wb_dst   (RegDstQ105H),
        .o_hazard   (HazardQ101H),
        .o_busy_vec (BusyVecQ101H)
    );

endmodule

// File: tb/tb_core_rrv_rf_sb.sv
// Self-checking bench: directed scenarios plus random traffic against a behavioural register-file model.
module tb_core_rrv_rf_sb;

    localparam int MSB = 15;
    localparam int NRD = 2;
    localparam int NWR = 2;

    logic        Clock = 1'b0;
    logic        Rst;
    logic [9:0]  RegSrcQ101H;
    logic        IssueValidQ101H;
    logic [4:0]  IssueDstQ101H;
    logic        IssueRegWrQ101H;
    logic [1:0]  RegWrEnQ105H;
    logic [9:0]  RegDstQ105H;
    logic [63:0] RegWrDataQ105H;
    logic        FlushQ101H;
    logic        ReadyQ102H;
    logic [31:0] PcQ101H;
    logic [31:0] ImmediateQ101H;
    logic [31:0] PcQ102H;
    logic [31:0] ImmediateQ102H;
    logic [63:0] RegRdDataQ102H;
    logic        HazardQ101H;
    logic [15:0] BusyVecQ101H;

    core_rrv_rf_sb #(.RF_NUM_MSB(MSB), .NUM_RD(NRD), .NUM_WR(NWR), .DATA_W(32)) dut (
        .Clock(Clock), .Rst(Rst), .RegSrcQ101H(RegSrcQ101H),
        .IssueValidQ101H(IssueValidQ101H), .IssueDstQ101H(IssueDstQ101H),
        .IssueRegWrQ101H(IssueRegWrQ101H), .RegWrEnQ105H(RegWrEnQ105H),
        .RegDstQ105H(RegDstQ105H), .RegWrDataQ105H(RegWrDataQ105H),
        .FlushQ101H(FlushQ101H), .ReadyQ102H(ReadyQ102H), .PcQ101H(PcQ101H),
        .ImmediateQ101H(ImmediateQ101H), .PcQ102H(PcQ102H), .ImmediateQ102H(ImmediateQ102H),
        .RegRdDataQ102H(RegRdDataQ102H), .HazardQ101H(HazardQ101H), .BusyVecQ101H(BusyVecQ101H)
    );

    always #5 Clock = ~Clock;

    int n_total = 0;
    int n_bad   = 0;

    // Behavioural model state
    logic [31:0] m_rf   [0:31];
    bit          m_busy [0:31];
    logic [31:0] m_pc, m_imm;
    logic [31:0] m_rd   [0:NRD-1];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit legal(input logic [4:0] idx);
        return (idx != 5'd0) && (int'(idx) <= MSB);
    endfunction

    function automatic logic [4:0] src_of(input int i);
        return RegSrcQ101H[i*5 +: 5];
    endfunction

    function automatic bit wb_hits(input logic [4:0] r);
        bit hit = 1'b0;
        for (int w = 0; w < NWR; w++)
            if (RegWrEnQ105H[w] && RegDstQ105H[w*5 +: 5] == r) hit = 1'b1;
        return hit;
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] s);
        logic [31:0] v;
        if (!legal(s)) return 32'd0;
        v = m_rf[s];
        for (int w = 0; w < NWR; w++)
            if (RegWrEnQ105H[w] && RegDstQ105H[w*5 +: 5] == s) v = RegWrDataQ105H[w*32 +: 32];
        return v;
    endfunction

    function automatic logic [15:0] model_busy_vec();
        logic [15:0] v = 16'd0;
        for (int r = 1; r <= MSB; r++) v[r] = m_busy[r];
        return v;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 32; r++) begin
            m_rf[r] = 32'd0;
            m_busy[r] = 1'b0;
        end
        m_pc = 32'd0;
        m_imm = 32'd0;
        for (int i = 0; i < NRD; i++) m_rd[i] = 32'd0;
    endtask

    // One cycle: check hazard with inputs settled, advance the model at the edge, then check registered outputs.
    task automatic tick();
        logic [31:0] e_rd [0:NRD-1];
        bit          e_haz;
        #1;
        e_haz = 1'b0;
        for (int i = 0; i < NRD; i++) begin
            if (legal(src_of(i)) && m_busy[src_of(i)] && !wb_hits(src_of(i))) e_haz = 1'b1;
            e_rd[i] = model_read(src_of(i));
        end
        chk("hazard", {63'd0, HazardQ101H}, {63'd0, e_haz});
        @(posedge Clock);
        if (Rst) begin
            model_reset();
        end else begin
            for (int w = 0; w < NWR; w++)
                if (RegWrEnQ105H[w] && legal(RegDstQ105H[w*5 +: 5]))
                    m_rf[RegDstQ105H[w*5 +: 5]] = RegWrDataQ105H[w*32 +: 32];
            for (int r = 1; r <= MSB; r++) begin
                if (FlushQ101H) m_busy[r] = 1'b0;
                else if (IssueValidQ101H && IssueRegWrQ101H && IssueDstQ101H == 5'(r)) m_busy[r] = 1'b1;
                else if (wb_hits(5'(r))) m_busy[r] = 1'b0;
            end
            if (ReadyQ102H) begin
                m_pc = PcQ101H;
                m_imm = ImmediateQ101H;
                for (int i = 0; i < NRD; i++) m_rd[i] = e_rd[i];
            end
        end
        #1;
        chk("pc_q102h", {32'd0, PcQ102H}, {32'd0, m_pc});
        chk("imm_q102h", {32'd0, ImmediateQ102H}, {32'd0, m_imm});
        for (int i = 0; i < NRD; i++)
            chk("rd_q102h", {32'd0, RegRdDataQ102H[i*32 +: 32]}, {32'd0, m_rd[i]});
        chk("busy_vec", {48'd0, BusyVecQ101H}, {48'd0, model_busy_vec()});
    endtask

    task automatic idle();
        Rst = 1'b0;
        RegSrcQ101H = 10'd0;
        IssueValidQ101H = 1'b0;
        IssueDstQ101H = 5'd0;
        IssueRegWrQ101H = 1'b0;
        RegWrEnQ105H = 2'b00;
        RegDstQ105H = 10'd0;
        RegWrDataQ105H = 64'd0;
        FlushQ101H = 1'b0;
        ReadyQ102H = 1'b0;
    endtask

    task automatic set_wr(input int p, input logic [4:0] dst, input logic [31:0] data);
        RegWrEnQ105H[p] = 1'b1;
        RegDstQ105H[p*5 +: 5] = dst;
        RegWrDataQ105H[p*32 +: 32] = data;
    endtask

    task automatic set_src(input int i, input logic [4:0] s);
        RegSrcQ101H[i*5 +: 5] = s;
    endtask

    task automatic issue(input logic [4:0] dst);
        IssueValidQ101H = 1'b1;
        IssueRegWrQ101H = 1'b1;
        IssueDstQ101H = dst;
    endtask

    initial begin
        idle();
        PcQ101H = 32'h0;
        ImmediateQ101H = 32'h0;
        Rst = 1'b1;
        repeat (2) @(posedge Clock);
        #1;
        model_reset();
        chk("reset_pc", {32'd0, PcQ102H}, 64'd0);
        chk("reset_rd", RegRdDataQ102H, 64'd0);
        chk("reset_busy", {48'd0, BusyVecQ101H}, 64'd0);
        Rst = 1'b0;
        #1;
        chk("reset_hazard", {63'd0, HazardQ101H}, 64'd0);

        // Write then read x5
        idle(); set_wr(0, 5'd5, 32'hDEADBEEF); tick();
        idle(); set_src(0, 5'd5); ReadyQ102H = 1'b1; tick();
        chk("x5_read", {32'd0, RegRdDataQ102H[31:0]}, 64'hDEADBEEF);

        // Same-cycle forward of x7, x0 never written
        idle(); set_wr(0, 5'd7, 32'h11); set_wr(1, 5'd0, 32'h55);
        set_src(0, 5'd7); set_src(1, 5'd0); ReadyQ102H = 1'b1; tick();
        chk("x7_fwd", {32'd0, RegRdDataQ102H[31:0]}, 64'h11);
        chk("x0_fwd", {32'd0, RegRdDataQ102H[63:32]}, 64'h0);
        idle(); set_src(1, 5'd0); ReadyQ102H = 1'b1; tick();
        chk("x0_read", {32'd0, RegRdDataQ102H[63:32]}, 64'h0);

        // Dual-port collision on x3; out-of-range x20 ignored
        idle(); set_wr(0, 5'd3, 32'hA); set_wr(1, 5'd3, 32'hB); tick();
        idle(); set_wr(0, 5'd20, 32'h1234); set_src(0, 5'd3); ReadyQ102H = 1'b1; tick();
        chk("x3_young", {32'd0, RegRdDataQ102H[31:0]}, 64'hB);
        idle(); set_src(1, 5'd20); ReadyQ102H = 1'b1; tick();
        chk("x20_read", {32'd0, RegRdDataQ102H[63:32]}, 64'h0);

        // Hazard on x9 and its clearing writeback
        idle(); issue(5'd9); tick();
        chk("busy_x9_set", {63'd0, BusyVecQ101H[9]}, 64'd1);
        idle(); set_src(0, 5'd9); #1;
        chk("hazard_x9", {63'd0, HazardQ101H}, 64'd1);
        tick();
        idle(); set_src(0, 5'd9); set_wr(0, 5'd9, 32'h99); ReadyQ102H = 1'b1; #1;
        chk("hazard_x9_fwd", {63'd0, HazardQ101H}, 64'd0);
        tick();
        chk("busy_x9_clr", {63'd0, BusyVecQ101H[9]}, 64'd0);
        chk("x9_fwd_data", {32'd0, RegRdDataQ102H[31:0]}, 64'h99);

        // Set beats clear; flush beats set
        idle(); issue(5'd4); set_wr(0, 5'd4, 32'h44); tick();
        chk("busy_x4_set_wins", {63'd0, BusyVecQ101H[4]}, 64'd1);
        idle(); issue(5'd6); FlushQ101H = 1'b1; tick();
        chk("flush_busy", {48'd0, BusyVecQ101H}, 64'd0);

        // Hold while not ready
        idle(); ReadyQ102H = 1'b1; PcQ101H = 32'h100; ImmediateQ101H = 32'h200; set_src(0, 5'd5); tick();
        for (int k = 0; k < 3; k++) begin
            idle(); PcQ101H = 32'h300 + k; ImmediateQ101H = 32'h400 + k; set_src(0, 5'd7); tick();
            chk("hold_pc", {32'd0, PcQ102H}, 64'h100);
            chk("hold_imm", {32'd0, ImmediateQ102H}, 64'h200);
            chk("hold_rd", {32'd0, RegRdDataQ102H[31:0]}, 64'hDEADBEEF);
        end

        // Reset mid-run: all outputs zero, concurrent write lost
        idle(); Rst = 1'b1; ReadyQ102H = 1'b1; issue(5'd2); set_wr(0, 5'd12, 32'h77); tick();
        chk("rst_pc", {32'd0, PcQ102H}, 64'd0);
        chk("rst_imm", {32'd0, ImmediateQ102H}, 64'd0);
        chk("rst_rd", RegRdDataQ102H, 64'd0);
        chk("rst_busy", {48'd0, BusyVecQ101H}, 64'd0);
        idle(); set_src(0, 5'd12); set_src(1, 5'd5); ReadyQ102H = 1'b1; tick();
        chk("rst_lost_wr", RegRdDataQ102H, 64'd0);

        // Random traffic against the model
        for (int c = 0; c < 1500; c++) begin
            idle();
            Rst = ($urandom_range(0, 99) == 0);
            for (int i = 0; i < NRD; i++)
                set_src(i, ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7)));
            IssueValidQ101H = 1'($urandom_range(0, 1));
            IssueRegWrQ101H = ($urandom_range(0, 3) != 0);
            IssueDstQ101H = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            for (int w = 0; w < NWR; w++)
                if ($urandom_range(0, 2) == 0)
                    set_wr(w, ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7)),
                           $urandom);
            FlushQ101H = ($urandom_range(0, 31) == 0);
            ReadyQ102H = ($urandom_range(0, 3) != 0);
            PcQ101H = $urandom;
            ImmediateQ101H = $urandom;
            tick();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
